mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 12, word address width into data block RAM.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, 8, wait cycles after which the loader forcibly wins (legal range 1..255).
REQ-004 SHALL have ports:
  - clk  in  1  single clock, all logic on its rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - cpu_req  in  1  CPU access request.
  - cpu_we  in  4  CPU byte write mask; 0 means read.
  - cpu_addr  in  ADDR_W  CPU address.
  - cpu_wdata  in  DATA_W  CPU write data.
  - cpu_stall  out  1  CPU access not taken this cycle; CPU holds its request.
  - cpu_rdata  out  DATA_W  CPU read data.
  - cpu_rvalid  out  1  cpu_rdata valid.
  - ld_req  in  1  loader/debug-port request, held until granted.
  - ld_we  in  4  loader byte write mask; 0 means read.
  - ld_addr  in  ADDR_W  loader address.
  - ld_wdata  in  DATA_W  loader write data.
  - ld_gnt  out  1  loader request accepted this cycle.
  - ld_rdata  out  DATA_W  loader read data.
  - ld_rvalid  out  1  ld_rdata valid.
  - ram_en  out  1  RAM enable.
  - ram_we  out  4  RAM byte write enables.
  - ram_addr  out  ADDR_W  RAM address.
  - ram_din  out  DATA_W  RAM write data.
  - ram_dout  in  DATA_W  RAM read data, one-cycle latency.

Function
REQ-005 SHALL issue at most one RAM access per cycle: ram_en=1 exactly when a request is granted; ram_we/addr/din driven combinationally from the granted port.
REQ-006 SHALL grant the CPU when cpu_req=1 and the starvation counter is below STARVE_MAX; otherwise it SHALL grant the loader if ld_req=1.
REQ-007 SHALL drive cpu_stall = cpu_req AND NOT cpu granted; ld_gnt = ld_req AND loader granted.
REQ-008 SHALL use an 8-bit starvation counter that increments each cycle ld_req=1 and ld_gnt=0, saturates at STARVE_MAX, and clears to 0 on ld_gnt or ld_req=0.
REQ-009 SHALL keep a read-return FSM with states RD_NONE, RD_CPU and RD_LD. The next state is set from the current grant: a granted read with we=0 goes to RD_CPU or RD_LD; anything else goes to RD_NONE.
REQ-010 SHALL assert cpu_rvalid exactly in RD_CPU and ld_rvalid exactly in RD_LD.
REQ-011 SHALL route ram_dout combinationally to both cpu_rdata and ld_rdata.
REQ-012 SHALL give writes no rvalid.
REQ-013 SHALL give back-to-back reads to alternating owners correct per-cycle rvalid with no bubbles.
REQ-014 SHALL grant the CPU when both requesters are present and the counter < STARVE_MAX. The loader SHALL be guaranteed a grant within STARVE_MAX+1 cycles of raising ld_req.
REQ-015 SHALL be idle when neither port requests: ram_en=0, ram_we=0, next FSM state RD_NONE.

Reset
REQ-016 SHALL, while reset=0, force the FSM to RD_NONE and the counter to 0.
REQ-017 SHALL, while reset=0, hold ram_en=0, ram_we=0, ld_gnt=0, cpu_rvalid=0 and ld_rvalid=0.
REQ-018 SHALL, while reset=0, drive cpu_stall=cpu_req.
REQ-019 SHALL, when reset asserts during a pending read, drop rvalid immediately and never deliver that read afterwards.
REQ-020 SHALL make its first grant possible on the first rising edge after reset deasserts.

Structure
REQ-021 SHALL place the read-return state encoding (RD_NONE/RD_CPU/RD_LD) and the 4-bit byte-mask width constant in a shared package, mem_pkg.
REQ-022 SHALL be a single module with no sub-modules.
REQ-023 SHALL keep all registers in one asynchronous-reset always block; grant logic is combinational.

Verification
REQ-024 CPU read @0x010 alone, RAM word 0xDEADBEEF -> ram_en=1 that cycle, cpu_stall=0, next cycle cpu_rvalid=1 with cpu_rdata=0xDEADBEEF, ld_rvalid=0.
REQ-025 cpu_req held high continuously, ld_req raised at cycle 0, STARVE_MAX=8 -> cpu_stall=0 for cycles 0..7; at cycle 8 ld_gnt=1 and cpu_stall=1; counter back to 0 at cycle 9.
REQ-026 Loader write ld_we=4'b0011 @0x7FF data 0x12345678, CPU idle -> ld_gnt=1 same cycle, ram_we=4'b0011, ram_addr=0x7FF, no rvalid next cycle.
REQ-027 CPU read cycle N, loader read cycle N+1 (forced) -> cpu_rvalid at N+1, ld_rvalid at N+2, each exactly one cycle.
REQ-028 Assert reset=0 one cycle after a granted CPU read -> cpu_rvalid never goes high, ram_en=0 throughout reset, cpu_stall mirrors cpu_req.
REQ-029 ld_req dropped before grant after 5 waiting cycles, then re-raised -> counter restarts from 0, loader forced only after a further 8 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the data-RAM arbiter.
// Read-return encoding and byte-mask width.
package mem_pkg;

  localparam int BE_W = 4;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_CPU  = 2'd1;
  localparam logic [1:0] RD_LD   = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM.
// CPU has priority; the loader wins after STARVE_MAX waits.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [BE_W-1:0]   cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ld_req,
  input  logic [BE_W-1:0]   ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  logic [7:0] cnt_q, cnt_d;
  logic [1:0] rd_q, rd_d;
  logic       cpu_win;
  logic       ld_win;

  // Grants are gated by reset so nothing reaches the RAM while held.
  assign cpu_win = reset & cpu_req & (cnt_q < SMAX);
  assign ld_win  = reset & ld_req & ~cpu_win;

  assign ram_en    = cpu_win | ld_win;
  assign cpu_stall = cpu_req & ~cpu_win;
  assign ld_gnt    = ld_win;

  assign cpu_rdata  = ram_dout;
  assign ld_rdata   = ram_dout;
  assign cpu_rvalid = reset & (rd_q == RD_CPU);
  assign ld_rvalid  = reset & (rd_q == RD_LD);

  // Steer the winning port onto the RAM and pick the read owner.
  always_comb begin
    ram_we   = '0;
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    rd_d     = RD_NONE;
    unique case (1'b1)
      cpu_win: begin
        ram_we = cpu_we;
        rd_d   = (cpu_we == '0) ? RD_CPU : RD_NONE;
      end
      ld_win: begin
        ram_we   = ld_we;
        ram_addr = ld_addr;
        ram_din  = ld_wdata;
        rd_d     = (ld_we == '0) ? RD_LD : RD_NONE;
      end
      default: ;
    endcase
  end

  // Starvation counter: counts loader waits, saturates, clears.
  always_comb begin
    cnt_d = cnt_q;
    if (!ld_req || ld_win) begin
      cnt_d = '0;
    end else if (cnt_q < SMAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      rd_q  <= RD_NONE;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a RAM model
// and a queue of expected read returns.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        ld_req;
  logic [3:0]  ld_we;
  logic [11:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic [31:0] ld_rdata;
  logic        ld_rvalid;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata),
    .ld_rvalid(ld_rvalid),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Single-port RAM, one-cycle read latency, byte writes.
  always @(posedge clk) begin
    if (!reset) begin
      mem[12'h010] <= 32'hDEADBEEF;
      mem[12'h020] <= 32'hCAFEF00D;
      mem[12'h030] <= 32'h0;
      mem[12'h7FF] <= 32'h0;
    end else if (ram_en) begin
      if (ram_we == 4'b0) begin
        ram_dout <= mem[ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive, check comb outputs and the pending return.
  task automatic step(
    input logic        rst,
    input logic        cr,
    input logic [3:0]  cwe,
    input logic [11:0] ca,
    input logic [31:0] cd,
    input logic        lr,
    input logic [3:0]  lwe,
    input logic [11:0] la,
    input logic [31:0] ldv,
    input logic        e_en,
    input logic        e_st,
    input logic        e_g,
    input logic [1:0]  e_nx,
    input logic [31:0] e_d);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    cpu_req   = cr;
    cpu_we    = cwe;
    cpu_addr  = ca;
    cpu_wdata = cd;
    ld_req    = lr;
    ld_we     = lwe;
    ld_addr   = la;
    ld_wdata  = ldv;
    #2;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    if (!rst) e = '0;
    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_st));
    chk("ld_gnt", 32'(ld_gnt), 32'(e_g));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.who == 2'd1));
    chk("ld_rvalid", 32'(ld_rvalid), 32'(e.who == 2'd2));
    if (e.who == 2'd1) chk("cpu_rdata", cpu_rdata, e.data);
    if (e.who == 2'd2) chk("ld_rdata", ld_rdata, e.data);
    if (!e_en) chk("ram_we_idle", 32'(ram_we), 32'h0);
    sb.push_back({e_nx, e_d});
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    sb.push_back('0);

    // In reset: no grants, stall mirrors request.
    step(0, 1, 0, 12'h010, 0, 1, 0, 12'h020, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lone CPU read.
    step(1, 1, 0, 12'h010, 0, 0, 0, 0, 0,
         1, 0, 0, 1, 32'hDEADBEEF);
    idle();

    // Loader partial write, then read it back.
    step(1, 0, 0, 0, 0, 1, 4'b0011, 12'h7FF, 32'h12345678,
         1, 0, 1, 0, 0);
    chk("wr_we", 32'(ram_we), 32'h3);
    chk("wr_addr", 32'(ram_addr), 32'h7FF);
    chk("wr_din", ram_din, 32'h12345678);
    idle();
    step(1, 0, 0, 0, 0, 1, 0, 12'h7FF, 0,
         1, 0, 1, 2, 32'h00005678);
    idle();

    // CPU streams, loader waits 8 then is forced in.
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 12'h020, 0, 1, 0, 12'h010, 0,
           1, 0, 0, 1, 32'hCAFEF00D);
    step(1, 1, 0, 12'h020, 0, 1, 0, 12'h010, 0,
         1, 1, 1, 2, 32'hDEADBEEF);
    // Counter cleared: CPU wins again.
    step(1, 1, 0, 12'h020, 0, 1, 0, 12'h010, 0,
         1, 0, 0, 1, 32'hCAFEF00D);
    step(1, 1, 0, 12'h020, 0, 0, 0, 0, 0,
         1, 0, 0, 1, 32'hCAFEF00D);

    // Loader gives up after 5 waits, then must wait 8 more.
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 12'h020, 0, 1, 0, 12'h010, 0,
           1, 0, 0, 1, 32'hCAFEF00D);
    step(1, 1, 0, 12'h020, 0, 0, 0, 0, 0,
         1, 0, 0, 1, 32'hCAFEF00D);
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 12'h020, 0, 1, 0, 12'h010, 0,
           1, 0, 0, 1, 32'hCAFEF00D);
    step(1, 1, 0, 12'h020, 0, 1, 0, 12'h010, 0,
         1, 1, 1, 2, 32'hDEADBEEF);
    idle();

    // CPU full and partial writes, read-back.
    step(1, 1, 4'hF, 12'h030, 32'hA5A55A5A, 0, 0, 0, 0,
         1, 0, 0, 0, 0);
    step(1, 1, 0, 12'h030, 0, 0, 0, 0, 0,
         1, 0, 0, 1, 32'hA5A55A5A);
    step(1, 1, 4'b1000, 12'h030, 32'hFF000000, 0, 0, 0, 0,
         1, 0, 0, 0, 0);
    step(1, 1, 0, 12'h030, 0, 0, 0, 0, 0,
         1, 0, 0, 1, 32'hFFA55A5A);
    idle();

    // Reset hits a pending CPU read: it is never delivered.
    step(1, 1, 0, 12'h010, 0, 0, 0, 0, 0,
         1, 0, 0, 1, 32'hDEADBEEF);
    step(0, 1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 12'h010, 0, 0, 0, 0, 0, 0);
    // First edge after release grants.
    step(1, 1, 0, 12'h010, 0, 0, 0, 0, 0,
         1, 0, 0, 1, 32'hDEADBEEF);
    idle();
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
